// File: rtl/mips_trace_buffer_if.sv
// Bus between Main_Top status taps, trace control and the trace-buffer read port.
// The optional TRACE_MEM_EN macro adds mem_out / rd_mem.
interface mips_trace_buffer_if #(
  parameter int CW = 5
);
  logic        arm;
  logic        abort;
  logic        flush;
  logic [15:0] trig_pc;
  logic [15:0] pc_addr;
  logic [5:0]  i_code;
  logic        zero;
  logic [31:0] alu_out;
  // Read handshake: an entry moves when rd_valid && rd_ready at a rising edge;
  // rd_valid never depends on rd_ready, and rd_* hold steady until accepted.
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_pc;
  logic [5:0]  rd_icode;
  logic        rd_zero;
  logic [31:0] rd_alu;
  logic [CW-1:0] count;
  logic [1:0]  state;
  logic        done;
`ifdef TRACE_MEM_EN
  logic [31:0] mem_out;
  logic [31:0] rd_mem;

  modport master (
    output arm, abort, flush, trig_pc, pc_addr, i_code, zero, alu_out, mem_out, rd_ready,
    input  rd_valid, rd_pc, rd_icode, rd_zero, rd_alu, rd_mem, count, state, done
  );
  modport slave (
    input  arm, abort, flush, trig_pc, pc_addr, i_code, zero, alu_out, mem_out, rd_ready,
    output rd_valid, rd_pc, rd_icode, rd_zero, rd_alu, rd_mem, count, state, done
  );
`else
  modport master (
    output arm, abort, flush, trig_pc, pc_addr, i_code, zero, alu_out, rd_ready,
    input  rd_valid, rd_pc, rd_icode, rd_zero, rd_alu, count, state, done
  );
  modport slave (
    input  arm, abort, flush, trig_pc, pc_addr, i_code, zero, alu_out, rd_ready,
    output rd_valid, rd_pc, rd_icode, rd_zero, rd_alu, count, state, done
  );
`endif
endinterface

// File: rtl/mips_trace_buffer.sv
// PC-triggered execution trace capture into a FWFT FIFO with a valid/ready drain port.
// Define TRACE_MEM_EN to also capture the memory read data (entries grow 55 -> 87 bits).
module mips_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  mips_trace_buffer_if.slave bus
);
  localparam int AW = CW - 1;
`ifdef TRACE_MEM_EN
  localparam int EW = 87;
`else
  localparam int EW = 55;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic          match;
  logic          full;
  logic          push;
  logic          pop;

  assign match = (bus.pc_addr == bus.trig_pc);
  assign full  = (count_q == CW'(DEPTH));

`ifdef TRACE_MEM_EN
  assign wr_entry = {bus.mem_out, bus.pc_addr, bus.i_code, bus.zero, bus.alu_out};
  assign bus.rd_mem = rd_entry[86:55];
`else
  assign wr_entry = {bus.pc_addr, bus.i_code, bus.zero, bus.alu_out};
`endif

  assign rd_entry     = mem_q[rd_ptr_q];
  assign bus.rd_pc    = rd_entry[54:39];
  assign bus.rd_icode = rd_entry[38:33];
  assign bus.rd_zero  = rd_entry[32];
  assign bus.rd_alu   = rd_entry[31:0];
  assign bus.rd_valid = (count_q != '0);
  assign bus.count    = count_q;
  assign bus.state    = state_q;
  assign bus.done     = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A full FIFO blocks the push even if a pop frees a slot this cycle.
    push = ((state_q == S_ARMED && match) || state_q == S_CAPTURE) && !full
           && !bus.abort && !bus.flush;
    pop  = (count_q != '0) && bus.rd_ready && !bus.flush;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (bus.abort) begin
      state_d = S_IDLE;
    end else if (!bus.flush) begin
      unique case (state_q)
        S_IDLE:    if (bus.arm) state_d = S_ARMED;
        // Matching while still full (re-arm without draining) drops the sample.
        S_ARMED:   if (match) state_d = (full || count_d == CW'(DEPTH)) ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (count_d == CW'(DEPTH)) state_d = S_DONE;
        S_DONE:    if (bus.arm) state_d = S_ARMED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: table-driven reset/trigger vectors plus
// hand-written capture, drain, push/pop, abort/flush and re-arm sequences.
module tb_mips_trace_buffer;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] salt;
  logic [15:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_trace_buffer_if #(.CW(CW)) bus ();

  mips_trace_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        arm;
    logic [15:0] pc;
    logic [1:0]  st;
    logic [4:0]  cnt;
    logic [15:0] head;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic ab, input logic fl,
                      input logic [15:0] pc, input logic rdy);
    bus.arm      = a;
    bus.abort    = ab;
    bus.flush    = fl;
    bus.pc_addr  = pc;
    bus.i_code   = pc[7:2];
    bus.zero     = pc[2];
    bus.alu_out  = {15'b0, pc, 1'b0} ^ salt;
`ifdef TRACE_MEM_EN
    bus.mem_out  = ~{16'b0, pc};
`endif
    bus.rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_st(input string name, input logic [1:0] st, input logic [4:0] cnt);
    chk({name, ".state"}, {30'b0, bus.state}, {30'b0, st});
    chk({name, ".count"}, {27'b0, bus.count}, {27'b0, cnt});
    chk({name, ".done"}, {31'b0, bus.done}, {31'b0, (st == 2'd3)});
    chk({name, ".rd_valid"}, {31'b0, bus.rd_valid}, {31'b0, (cnt != 5'd0)});
  endtask

  task automatic check_head(input string name, input logic [15:0] pc);
    chk({name, ".rd_valid"}, {31'b0, bus.rd_valid}, 32'd1);
    chk({name, ".rd_pc"}, {16'b0, bus.rd_pc}, {16'b0, pc});
    chk({name, ".rd_icode"}, {26'b0, bus.rd_icode}, {26'b0, pc[7:2]});
    chk({name, ".rd_zero"}, {31'b0, bus.rd_zero}, {31'b0, pc[2]});
    chk({name, ".rd_alu"}, bus.rd_alu, {15'b0, pc, 1'b0});
`ifdef TRACE_MEM_EN
    chk({name, ".rd_mem"}, bus.rd_mem, ~{16'b0, pc});
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    salt  = 32'h0;
    rst_n = 1'b0;
    bus.trig_pc = 16'h0004;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.flush = 1'b0;
    bus.pc_addr = '0; bus.i_code = '0; bus.zero = 1'b0; bus.alu_out = '0;
`ifdef TRACE_MEM_EN
    bus.mem_out = '0;
`endif
    bus.rd_ready = 1'b0;

    // rst_n, arm, pc -> state, count, head pc after the edge
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 2'd0, 5'd0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 2'd0, 5'd0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0000, 2'd1, 5'd0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 2'd1, 5'd0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h0004, 2'd2, 5'd1, 16'h0004};
    vecs[5] = '{1'b1, 1'b0, 16'h0008, 2'd2, 5'd2, 16'h0004};

    for (int i = 0; i < 16; i++) exp_q.push_back(16'(4 + 4 * i));

    for (int i = 0; i < 6; i++) begin
      rst_n = vecs[i].rst_n;
      step(vecs[i].arm, 1'b0, 1'b0, vecs[i].pc, 1'b0);
      check_st($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt);
      if (vecs[i].cnt != 5'd0) check_head($sformatf("vec%0d", i), vecs[i].head);
    end

    // Finish the capture: one push per cycle until full.
    for (int k = 2; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'(4 + 4 * k), 1'b0);
      check_st($sformatf("cap%0d", k), (k == 15) ? 2'd3 : 2'd2, 5'(k + 1));
    end
    step(1'b0, 1'b0, 1'b0, 16'h0044, 1'b0);
    check_st("done_hold", 2'd3, 5'd16);

    // Drain while full; DONE must persist.
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("drain%0d", i), exp_q.pop_front());
      step(1'b0, 1'b0, 1'b0, 16'h0100, 1'b1);
    end
    check_st("drained", 2'd3, 5'd0);

    // Simultaneous push/pop keeps count at 1.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_st("pp_arm", 2'd1, 5'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0004, 1'b1);
    check_st("pp_trig", 2'd2, 5'd1);
    for (int k = 1; k < 20; k++) begin
      check_head($sformatf("pp_head%0d", k), 16'(4 * k));
      step(1'b0, 1'b0, 1'b0, 16'(4 + 4 * k), 1'b1);
      check_st($sformatf("pp%0d", k), 2'd2, 5'd1);
    end
    for (int j = 0; j < 15; j++) begin
      step(1'b0, 1'b0, 1'b0, 16'(84 + 4 * j), 1'b0);
      check_st($sformatf("pp_fill%0d", j), (j == 14) ? 2'd3 : 2'd2, 5'(2 + j));
    end
    check_head("pp_full_head", 16'd80);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    check_st("pp_flush", 2'd3, 5'd0);

    // Abort after five pushes keeps data; flush then empties.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_st("ab_arm", 2'd1, 5'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'(4 + 4 * k), 1'b0);
      check_st($sformatf("ab_cap%0d", k), 2'd2, 5'(k + 1));
    end
    step(1'b0, 1'b1, 1'b0, 16'h0018, 1'b0);
    check_st("ab_abort", 2'd0, 5'd5);
    for (int k = 0; k < 3; k++) begin
      check_head($sformatf("ab_rd%0d", k), 16'(4 + 4 * k));
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      check_st($sformatf("ab_pop%0d", k), 2'd0, 5'(4 - k));
    end
    check_head("ab_rd3", 16'h0010);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    check_st("ab_flush", 2'd0, 5'd0);

    // Re-arm from DONE while full: trigger sample dropped, straight to DONE.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b0, 16'(4 + 4 * k), 1'b0);
    check_st("ra_full", 2'd3, 5'd16);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_st("ra_arm", 2'd1, 5'd16);
    salt = 32'hdead0000;
    step(1'b0, 1'b0, 1'b0, 16'h0004, 1'b0);
    salt = 32'h0;
    check_st("ra_match", 2'd3, 5'd16);
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("ra_drain%0d", i), 16'(4 + 4 * i));
      step(1'b0, 1'b0, 1'b0, 16'h0100, 1'b1);
    end
    check_st("ra_empty", 2'd3, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
